// File: rtl/key_loader.sv
// key_loader: gathers four 32-bit key words into a 128-bit cipher key. The
// committed key is held stable on 'key' while the AES-128 key expansion
// pipeline settles. keys_valid flags when every round key matches 'key'.
//
// Handshake: a key_word is transferred on a rising edge where key_word_valid
// and key_word_ready are both high. key_word_ready depends on rst and state
// only; it never looks at key_word_valid. Upstream holds key_word steady
// while ready is low. Words offered while ready is low are not taken.
module key_loader #(
  parameter int SETTLE_CYCLES = 9,
  parameter int ID_W          = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [0:31]     key_word,
  input  logic            key_word_valid,
  output logic            key_word_ready,
  input  logic            key_abort,
  output logic [0:127]    key,
  output logic            keys_valid,
  output logic [ID_W-1:0] key_id,
  output logic [1:0]      word_cnt,
  output logic [1:0]      fsm_state
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2
  } state_t;

  state_t           state;
  logic [0:95]      shadow;
  logic [CNT_W-1:0] settle_cnt;
  logic             accept;

  // Ready is low during SETTLE so 'key' cannot change under the pipeline.
  assign key_word_ready = !rst && (state != SETTLE);
  assign accept         = key_word_valid && key_word_ready;
  assign fsm_state      = state;

  // Settle countdown, word collection, commit and abort handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      key        <= '0;
      keys_valid <= 1'b0;
      key_id     <= '0;
      word_cnt   <= 2'd0;
      shadow     <= '0;
      settle_cnt <= '0;
    end else begin
      // Countdown first; a commit later in this block overrides the state.
      // A commit cannot happen in SETTLE because ready is low there.
      if (state == SETTLE) begin
        if (settle_cnt == '0) begin
          state      <= VALID;
          keys_valid <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt - CNT_W'(1);
        end
      end

      if (key_abort) begin
        // Abort beats any word taken on the same edge: that word is dropped.
        word_cnt <= 2'd0;
        shadow   <= '0;
      end else if (accept) begin
        if (word_cnt == 2'd3) begin
          key        <= {shadow, key_word};
          word_cnt   <= 2'd0;
          shadow     <= '0;
          key_id     <= key_id + ID_W'(1);
          keys_valid <= 1'b0;
          state      <= SETTLE;
          settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          case (word_cnt)
            2'd0:    shadow[0:31]  <= key_word;
            2'd1:    shadow[32:63] <= key_word;
            default: shadow[64:95] <= key_word;
          endcase
          word_cnt <= word_cnt + 2'd1;
        end
      end
    end
  end

endmodule
